axi_ram_slave: RTL
==================

// Module: axi_ram_slave
// PURPOSE: AXI3 responder (slave) backed by a word-organised RAM, the far end of the CPU top's AXI master port.
//   Used in simulation and FPGA bring-up in place of the SoC crossbar + RAM, so the CPU's AXI bridge can be exercised
//   standalone. Independent read and write channels, each with one outstanding transaction and INCR bursts of up to 16 beats.
// PARAMETERS:
//   ADDR_W    16  word-address width; RAM holds 2**ADDR_W 32-bit words; byte address bits [ADDR_W+1:2] index it
//   READ_LAT  2   extra cycles from AR handshake to first rvalid (0..15)
// PORTS:
//   clk      in   1   clock, all logic on posedge
//   resetn   in   1   synchronous active-low reset
//   arid     in   4   read transaction ID
//   araddr   in   32  read byte address; bits [1:0] and above ADDR_W+1 ignored
//   arlen    in   8   beats-1; only [3:0] used
//   arvalid  in   1   read address valid
//   arready  out  1   read address accepted
//   rid      out  4   ID of current read beat (= latched arid)
//   rdata    out  32  read data
//   rresp    out  2   always 2'b00 (OKAY)
//   rlast    out  1   final beat of burst
//   rvalid   out  1   read beat valid
//   rready   in   1   master accepts read beat
//   awid     in   4   write transaction ID
//   awaddr   in   32  write byte address; same decode as araddr
//   awlen    in   8   beats-1; only [3:0] used
//   awvalid  in   1   write address valid
//   awready  out  1   write address accepted
//   wdata    in   32  write data
//   wstrb    in   4   byte enables; byte i written iff wstrb[i]
//   wlast    in   1   master's last-beat marker
//   wvalid   in   1   write data valid
//   wready   out  1   write data accepted
//   bid      out  4   write response ID (= latched awid)
//   bresp    out  2   2'b00 OKAY, 2'b10 SLVERR on wlast mismatch
//   bvalid   out  1   write response valid
//   bready   in   1   master accepts response
// BEHAVIOUR:
// - Reset (resetn=0 at posedge): arready=1, awready=1, wready=0, rvalid=0, rlast=0, bvalid=0, rdata/rid/bid/rresp/bresp=0;
//   both FSMs to IDLE; RAM contents NOT cleared. Reset mid-burst abandons the burst, no partial response emitted.
// - Read FSM R_IDLE -> R_WAIT -> R_DATA. R_IDLE: arready=1; on arvalid&arready latch arid, word addr, beat count arlen[3:0],
//   clear latency counter, go R_WAIT (arready=0). R_WAIT: count READ_LAT cycles (READ_LAT=0: one cycle), then load
//   rdata<=mem[addr], go R_DATA. R_DATA: rvalid=1; rdata/rid/rlast held stable while rready=0.
//   On rvalid&rready: last beat -> R_IDLE (arready=1 next cycle); else addr+1 (wraps mod 2**ADDR_W), load next rdata same
//   edge, rvalid stays 1 (back-to-back beats). rlast=1 only on beat arlen[3:0]+1.
// - Write FSM W_IDLE -> W_DATA -> W_RESP. W_IDLE: awready=1; on handshake latch awid, word addr, count, go W_DATA.
//   W_DATA: wready=1; each wvalid&wready commits wstrb-selected bytes to mem[addr] at that edge, addr+1 (wrap).
//   Error flag set if wlast=1 on a non-final beat or wlast=0 on the final beat; burst length follows awlen regardless.
//   After final beat -> W_RESP: bvalid=1, bresp = err ? 2'b10 : 2'b00, held until bready; then W_IDLE, flag cleared.
// - W data arriving before AW handshake is not accepted (wready=0 outside W_DATA).
// - Same-cycle write commit and read-data load to the same word: read captures pre-write value.
// - Read and write FSMs never stall each other; arready and awready may both be 1.
// CONFIGURATION: AXI_SLV_DELAY_EN
//   defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) steps every cycle; arready/awready/wready are ANDed with
//   lfsr[0]; a pending rvalid/bvalid first rises only in a cycle with lfsr[1]=1, then is held until handshake (AXI-legal).
//   undefined: no gating, timing exactly as above.
// TESTING:
//   1 write 0x12345678 to 0x40 (awlen=0, wstrb=F, awid=2) -> bvalid, bid=2, bresp=0; read 0x40 arid=3 -> rvalid exactly
//     READ_LAT+1 cycles after AR handshake, rdata=0x12345678, rid=3, rlast=1, rresp=0
//   2 mem[0x80]=0xFFFFFFFF; write 0xAABBCCDD wstrb=4'b0011 -> read 0x80 returns 0xFFFFCCDD
//   3 burst read arlen=3 at 0x100 (words 1,2,3,4); rready=0 for 2 cycles on beat 2 -> 4 beats 1,2,3,4, rdata stable
//     during stall, rlast only on beat 4; arready=0 until cycle after beat 4
//   4 awlen=1 with wlast=1 on beat 0 -> both beats written, bresp=2'b10; next clean write -> bresp=2'b00
//   5 resetn=0 one cycle during beat 2 of arlen=7 -> next cycle rvalid=0, arready=1; re-read returns unchanged RAM data
//   6 with AXI_SLV_DELAY_EN: 200 random read/write pairs vs scoreboard -> zero mismatches, no valid drop before ready

Source files
------------

// File: rtl/axi_ram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_ram_slave_if
//   AXI3 channel bundle between a CPU-side AXI master and axi_ram_slave.
//   Holds the AR, R, AW, W and B channel signals; clock and reset are kept
//   outside the bundle as plain module ports.
//
//   Signals (width, driven by):
//     arid[4] araddr[32] arlen[8] arvalid   master  read address channel
//     arready                               slave
//     rid[4] rdata[32] rresp[2] rlast rvalid slave  read data channel
//     rready                                master
//     awid[4] awaddr[32] awlen[8] awvalid   master  write address channel
//     awready                               slave
//     wdata[32] wstrb[4] wlast wvalid       master  write data channel
//     wready                                slave
//     bid[4] bresp[2] bvalid                slave   write response channel
//     bready                                master
//
//   Modports: slave (used by axi_ram_slave), master (used by the requester).
// ---------------------------------------------------------------------------
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// ---------------------------------------------------------------------------
// axi_ram_slave
//   AXI3 responder backed by a word-organised RAM of 2**ADDR_W 32-bit words.
//   Stands in for the SoC crossbar + RAM so the CPU's AXI bridge can run
//   standalone. Read and write channels are independent, each with one
//   outstanding INCR burst of up to 16 beats (only arlen/awlen[3:0] used).
//   Byte address bits [ADDR_W+1:2] select the word; bursts wrap modulo the
//   RAM size. RAM contents are not cleared by reset.
//
//   Parameters:
//     ADDR_W    word-address width
//     READ_LAT  extra cycles between AR handshake and first read beat (0..15);
//               first rvalid appears READ_LAT+1 cycles after the handshake
//
//   Ports:
//     clk     in   clock, all logic on posedge
//     resetn  in   synchronous active-low reset
//     s_axi   axi_ram_slave_if.slave  AR/R/AW/W/B channels
//
//   Optional feature (macro AXI_SLV_DELAY_EN):
//     An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) steps every cycle.
//     arready/awready/wready are ANDed with lfsr[0]; a pending rvalid/bvalid
//     first rises only in a cycle where lfsr[1]=1 and is then held until the
//     handshake. Undefined: no gating.
// ---------------------------------------------------------------------------
module axi_ram_slave #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned READ_LAT = 2
) (
    input  logic           clk,
    input  logic           resetn,
    axi_ram_slave_if.slave s_axi
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    localparam logic [3:0] LP_LAT = 4'(READ_LAT);

    logic [31:0] r_mem [2**ADDR_W];

    // read channel state
    rstate_t           r_rstate;
    logic [ADDR_W-1:0] r_raddr;
    logic [3:0]        r_rcnt;
    logic [3:0]        r_lat;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [31:0]       r_rdata;
    logic [3:0]        r_rid;

    // write channel state
    wstate_t           r_wstate;
    logic [ADDR_W-1:0] r_waddr;
    logic [3:0]        r_wcnt;
    logic              r_awready;
    logic              r_wready;
    logic              r_werr;
    logic              r_bvalid;
    logic [3:0]        r_bid;
    logic [1:0]        r_bresp;

    logic              w_rdy_gate;
    logic              w_vld_gate;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_mem_we;
    logic              w_wlast_bad;
    logic [ADDR_W-1:0] w_raddr_nxt;
    logic              w_unused_bits;

`ifdef AXI_SLV_DELAY_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_rdy_gate = r_lfsr[0];
    // r_lfsr[0] becomes lfsr[1] after the shift, so a valid registered on
    // this edge first shows in a cycle where lfsr[1]=1.
    assign w_vld_gate = r_lfsr[0];
`else
    assign w_rdy_gate = 1'b1;
    assign w_vld_gate = 1'b1;
`endif

    // outputs come straight from registers (ready flags masked by the gate)
    assign s_axi.arready = r_arready & w_rdy_gate;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rid     = r_rid;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.awready = r_awready & w_rdy_gate;
    assign s_axi.wready  = r_wready & w_rdy_gate;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bid     = r_bid;
    assign s_axi.bresp   = r_bresp;

    assign w_ar_hs     = s_axi.arvalid & s_axi.arready;
    assign w_r_hs      = r_rvalid & s_axi.rready;
    assign w_aw_hs     = s_axi.awvalid & s_axi.awready;
    assign w_w_hs      = s_axi.wvalid & s_axi.wready;
    assign w_raddr_nxt = r_raddr + ADDR_W'(1);

    // wlast must be high exactly on the final beat
    assign w_wlast_bad = s_axi.wlast ^ (r_wcnt == 4'd0);

    // no commit in a reset cycle, so an abandoned burst leaves RAM untouched
    assign w_mem_we    = resetn & (r_wstate == W_DATA) & w_w_hs;

    // address bits outside the word index and arlen/awlen[7:4] are ignored
    assign w_unused_bits = &{1'b0, s_axi.araddr, s_axi.awaddr, s_axi.arlen, s_axi.awlen};

    // ------------------------------------------------------------------
    // RAM write port (byte enables). Reads elsewhere see the pre-write
    // value when both touch the same word on one edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (s_axi.wstrb[i]) begin
                    r_mem[r_waddr][8*i +: 8] <= s_axi.wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rcnt    <= '0;
            r_lat     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= s_axi.arid;
                        r_raddr   <= s_axi.araddr[ADDR_W+1:2];
                        r_rcnt    <= s_axi.arlen[3:0];
                        r_lat     <= '0;
                        r_arready <= 1'b0;
                        r_rstate  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // READ_LAT+1 cycles here in total (one for READ_LAT=0)
                    if (r_lat == LP_LAT) begin
                        r_rdata  <= r_mem[r_raddr];
                        r_rlast  <= (r_rcnt == 4'd0);
                        r_rvalid <= w_vld_gate;
                        r_rstate <= R_DATA;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                R_DATA: begin
                    if (!r_rvalid) begin
                        r_rvalid <= w_vld_gate;
                    end else if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            // next beat loaded on the accepting edge: no bubble
                            r_raddr <= w_raddr_nxt;
                            r_rcnt  <= r_rcnt - 4'd1;
                            r_rdata <= r_mem[w_raddr_nxt];
                            r_rlast <= (r_rcnt == 4'd1);
                        end
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
            r_werr    <= 1'b0;
            r_waddr   <= '0;
            r_wcnt    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid     <= s_axi.awid;
                        r_waddr   <= s_axi.awaddr[ADDR_W+1:2];
                        r_wcnt    <= s_axi.awlen[3:0];
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr <= r_waddr + ADDR_W'(1);
                        r_wcnt  <= r_wcnt - 4'd1;
                        if (r_wcnt == 4'd0) begin
                            // burst length follows awlen; a bad wlast only flags SLVERR
                            r_wready <= 1'b0;
                            r_bresp  <= (r_werr | w_wlast_bad) ? 2'b10 : 2'b00;
                            r_bvalid <= w_vld_gate;
                            r_wstate <= W_RESP;
                        end else begin
                            r_werr <= r_werr | w_wlast_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (!r_bvalid) begin
                        r_bvalid <= w_vld_gate;
                    end else if (s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
